// File: rtl/comp_rx_pkg.sv
// comp_rx_pkg: shared constants and types for the comparator bitstream receiver.
//   NBITS_DEF  - default decisions per conversion (word width)
//   CH_W_DEF   - default channel tag width (matches the 4-bit mux select)
//   FIFO_DEPTH - output buffer depth
//   state_e    - conversion FSM states
package comp_rx_pkg;
    localparam int NBITS_DEF  = 16;
    localparam int CH_W_DEF   = 4;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;
endpackage

// File: rtl/comp_rx_if.sv
// comp_rx_if: link-side inputs and the valid/ready word output of comp_rx.
//   comp_in/seq_init/comp_strobe/mux_sel - from the LVDS receiver
//   out_data/out_chan/out_valid/out_ready - assembled-word stream
// The slave modport is the receiver; master is the producer/consumer side.
interface comp_rx_if
    import comp_rx_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int CH_W  = CH_W_DEF
);
    logic             comp_in;
    logic             seq_init;
    logic             comp_strobe;
    logic [CH_W-1:0]  mux_sel;
    logic [NBITS-1:0] out_data;
    logic [CH_W-1:0]  out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output comp_in, seq_init, comp_strobe, mux_sel, out_ready,
        input  out_data, out_chan, out_valid
    );

    modport slave (
        input  comp_in, seq_init, comp_strobe, mux_sel, out_ready,
        output out_data, out_chan, out_valid
    );
endinterface

// File: rtl/comp_rx_fifo.sv
// comp_rx_fifo: 2-entry synchronous FIFO, slot 0 is always the head so the
// output comes straight from a register.
//   clk, rst_n  - clock, async active-low reset (empties the FIFO, zeroes data)
//   push, din   - write request and data; ignored when full unless popping
//   full        - both slots occupied
//   pop         - remove head; ignored when empty
//   empty, dout - head status and head data
module comp_rx_fifo
    import comp_rx_pkg::*;
#(
    parameter int W = NBITS_DEF + CH_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic                  w_pop;
    logic                  w_push;

    assign full   = &r_vld;
    assign empty  = ~r_vld[0];
    assign dout   = r_mem[0];
    assign w_pop  = pop && r_vld[0];
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_vld <= '0;
        end else if (w_pop) begin
            // Shift tail into head, then land the new word in whichever slot
            // is the first free one after the shift.
            r_mem[0] <= r_mem[1];
            r_vld[0] <= r_vld[1];
            r_vld[1] <= 1'b0;
            if (w_push) begin
                if (r_vld[1]) begin
                    r_mem[1] <= din;
                    r_vld[1] <= 1'b1;
                end else begin
                    r_mem[0] <= din;
                    r_vld[0] <= 1'b1;
                end
            end
        end else if (w_push) begin
            if (r_vld[0]) begin
                r_mem[1] <= din;
                r_vld[1] <= 1'b1;
            end else begin
                r_mem[0] <= din;
                r_vld[0] <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/comp_rx.sv
// comp_rx: assembles successive-approximation decisions from the selected
// comparator bitstream into NBITS words tagged with the captured channel, and
// buffers them in a 2-entry FIFO behind a valid/ready output.
//   clk, rst_n - clock, async active-low reset
//   bus        - link inputs and word output stream (comp_rx_if.slave)
//   clear_err  - clears both sticky flags (wins over a same-cycle set)
//   overflow   - sticky: completed word dropped, FIFO full
//   frame_err  - sticky: seq_init arrived mid-conversion
//   word_cnt   - words accepted into the FIFO, wrapping
module comp_rx
    import comp_rx_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int CH_W  = CH_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    comp_rx_if.slave    bus,
    input  logic        clear_err,
    output logic        overflow,
    output logic        frame_err,
    output logic [15:0] word_cnt
);
    localparam int CNT_W = $clog2(NBITS);
    localparam int W     = NBITS + CH_W;

    state_e            r_state, w_state_nxt;
    logic [NBITS-1:0]  r_sreg;
    logic [NBITS-1:0]  w_sreg_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CH_W-1:0]   r_chan;
    logic              w_word_done;
    logic              w_abort;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [W-1:0]      w_fifo_dout;

    assign w_sreg_shift = {r_sreg[NBITS-2:0], bus.comp_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // seq_init always wins over a same-cycle strobe, in either state.
    always_comb begin
        w_state_nxt = r_state;
        w_word_done = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.seq_init) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (bus.seq_init) begin
                    w_abort = 1'b1;
                end else if (bus.comp_strobe &&
                             r_bit_cnt == CNT_W'(NBITS - 1)) begin
                    w_word_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_chan    <= '0;
        end else if (bus.seq_init) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
            r_chan    <= bus.mux_sel;
        end else if (r_state == COLLECT && bus.comp_strobe) begin
            r_sreg    <= w_sreg_shift;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign w_pop     = !w_fifo_empty && bus.out_ready;
    assign w_push_ok = w_word_done && (!w_fifo_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
        end else begin
            if (clear_err)                      overflow  <= 1'b0;
            else if (w_word_done && !w_push_ok) overflow  <= 1'b1;
            if (clear_err)                      frame_err <= 1'b0;
            else if (w_abort)                   frame_err <= 1'b1;
            if (w_push_ok) word_cnt <= word_cnt + 16'd1;
        end
    end

    // The word enters the FIFO on the edge that samples the final decision,
    // so it shows at the head one cycle later with no extra stage.
    comp_rx_fifo #(.W(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_word_done),
        .full  (w_fifo_full),
        .pop   (w_pop),
        .empty (w_fifo_empty),
        .din   ({w_sreg_shift, r_chan}),
        .dout  (w_fifo_dout)
    );

    assign bus.out_valid = !w_fifo_empty;
    assign bus.out_data  = w_fifo_dout[W-1:CH_W];
    assign bus.out_chan  = w_fifo_dout[CH_W-1:0];
endmodule
